// File: rtl/simon_pkg.sv
// Shared types and width helpers for the Simon Says sequencer.
package simon_pkg;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_ADD      = 3'd1;
  localparam logic [2:0] ST_SHOW_ON  = 3'd2;
  localparam logic [2:0] ST_SHOW_OFF = 3'd3;
  localparam logic [2:0] ST_INPUT    = 3'd4;
  localparam logic [2:0] ST_WON      = 3'd5;
  localparam logic [2:0] ST_LOST     = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE     = ST_IDLE,
    S_ADD      = ST_ADD,
    S_SHOW_ON  = ST_SHOW_ON,
    S_SHOW_OFF = ST_SHOW_OFF,
    S_INPUT    = ST_INPUT,
    S_WON      = ST_WON,
    S_LOST     = ST_LOST
  } simon_state_e;

  typedef logic [1:0] colour_t;

  function automatic int lw_f(input int max_len);
    return $clog2(max_len + 1);
  endfunction

  // Memory address width; a single-entry memory still needs one address bit.
  function automatic int aw_f(input int max_len);
    return (max_len > 1) ? $clog2(max_len) : 1;
  endfunction

  function automatic int tw_f(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/simon_seq_mem.sv
// Colour sequence storage: one synchronous write port, one combinational read port.
module simon_seq_mem
  import simon_pkg::*;
#(
  parameter int MAX_LEN = 16,
  parameter int AW      = 4
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  colour_t       i_wdata,
  input  logic [AW-1:0] i_raddr,
  output colour_t       o_rdata
);

  colour_t r_mem [MAX_LEN];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/simon_seq_ctrl.sv
// Simon Says game sequencer: grows, plays back and checks the colour sequence.
//
// state    | meaning
// IDLE     | no game yet; wait for start
// ADD      | append rand_in to the sequence, bump level
// SHOW_ON  | light mem[index] for ON_CYCLES
// SHOW_OFF | dark gap for OFF_CYCLES, then next colour or input phase
// INPUT    | compare presses against mem[index], optional timeout
// WON      | full-length sequence repeated; wait for start
// LOST     | wrong press or timeout; wait for start
module simon_seq_ctrl
  import simon_pkg::*;
#(
  parameter  int MAX_LEN        = 16,
  parameter  int ON_CYCLES      = 25000000,
  parameter  int OFF_CYCLES     = 12500000,
  parameter  int TIMEOUT_CYCLES = 0,
  localparam int LW             = lw_f(MAX_LEN)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [1:0]    rand_in,
  input  logic          btn_valid,
  input  logic [1:0]    btn_code,
  output logic          led_en,
  output logic [1:0]    led_code,
  output logic          awaiting_input,
  output logic [LW-1:0] level,
  output logic          game_won,
  output logic          game_over
);

  localparam int AW = aw_f(MAX_LEN);
  localparam int TW = tw_f(ON_CYCLES, OFF_CYCLES, TIMEOUT_CYCLES);
  localparam logic [TW-1:0] ON_LAST  = TW'(ON_CYCLES - 1);
  localparam logic [TW-1:0] OFF_LAST = TW'(OFF_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  simon_state_e    r_state;
  logic [LW-1:0]   r_level;
  logic [LW-1:0]   r_index;
  logic [TW-1:0]   r_timer;
  colour_t         w_rd;
  logic            w_last;
  logic            w_we;

  assign w_we   = (r_state == S_ADD);
  assign w_last = (r_index == r_level - LW'(1));

  simon_seq_mem #(
    .MAX_LEN (MAX_LEN),
    .AW      (AW)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (r_level[AW-1:0]),
    .i_wdata (rand_in),
    .i_raddr (r_index[AW-1:0]),
    .o_rdata (w_rd)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_level <= '0;
      r_index <= '0;
      r_timer <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_WON, S_LOST: begin
          if (start) begin
            r_level <= '0;
            r_state <= S_ADD;
          end
        end
        S_ADD: begin
          r_level <= r_level + LW'(1);
          r_index <= '0;
          r_timer <= '0;
          r_state <= S_SHOW_ON;
        end
        S_SHOW_ON: begin
          if (r_timer == ON_LAST) begin
            r_timer <= '0;
            r_state <= S_SHOW_OFF;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        S_SHOW_OFF: begin
          if (r_timer == OFF_LAST) begin
            r_timer <= '0;
            if (w_last) begin
              r_index <= '0;
              r_state <= S_INPUT;
            end else begin
              r_index <= r_index + LW'(1);
              r_state <= S_SHOW_ON;
            end
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        S_INPUT: begin
          // A press in the timeout cycle wins over the timeout.
          if (btn_valid) begin
            if (btn_code != w_rd) begin
              r_state <= S_LOST;
            end else if (w_last) begin
              r_state <= (r_level == LW'(MAX_LEN)) ? S_WON : S_ADD;
            end else begin
              r_index <= r_index + LW'(1);
              r_timer <= '0;
            end
          end else if (TIMEOUT_CYCLES != 0) begin
            if (r_timer == TO_LAST) r_state <= S_LOST;
            else                    r_timer <= r_timer + TW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign led_en         = (r_state == S_SHOW_ON);
  assign led_code       = (r_state == S_SHOW_ON) ? w_rd : 2'd0;
  assign awaiting_input = (r_state == S_INPUT);
  assign level          = r_level;
  assign game_won       = (r_state == S_WON);
  assign game_over      = (r_state == S_LOST);

endmodule

// File: tb/tb_simon_seq_ctrl.sv
// Randomized self-checking bench for simon_seq_ctrl against a timeline model of the game.
module tb_simon_seq_ctrl;

  localparam int MAX_LEN = 3;
  localparam int ON_C    = 2;
  localparam int OFF_C   = 1;
  localparam int TO_C    = 6;
  localparam int LW      = $clog2(MAX_LEN + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [1:0]    rand_in = 2'd0;
  logic          btn_valid = 1'b0;
  logic [1:0]    btn_code = 2'd0;
  logic          led_en, awaiting_input, game_won, game_over;
  logic [1:0]    led_code;
  logic [LW-1:0] level;
  logic          nt_led_en, nt_awaiting_input, nt_game_won, nt_game_over;
  logic [1:0]    nt_led_code;
  logic [LW-1:0] nt_level;

  int n_tests = 0;
  int n_fail  = 0;
  int seq[$];
  bit noise = 1'b0;

  always #5 clk = ~clk;

  simon_seq_ctrl #(
    .MAX_LEN(MAX_LEN), .ON_CYCLES(ON_C), .OFF_CYCLES(OFF_C), .TIMEOUT_CYCLES(TO_C)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .rand_in(rand_in),
    .btn_valid(btn_valid), .btn_code(btn_code),
    .led_en(led_en), .led_code(led_code), .awaiting_input(awaiting_input),
    .level(level), .game_won(game_won), .game_over(game_over)
  );

  // Same stimulus, timeout disabled.
  simon_seq_ctrl #(
    .MAX_LEN(MAX_LEN), .ON_CYCLES(ON_C), .OFF_CYCLES(OFF_C), .TIMEOUT_CYCLES(0)
  ) dut_nt (
    .clk(clk), .rst(rst), .start(start), .rand_in(rand_in),
    .btn_valid(btn_valid), .btn_code(btn_code),
    .led_en(nt_led_en), .led_code(nt_led_code), .awaiting_input(nt_awaiting_input),
    .level(nt_level), .game_won(nt_game_won), .game_over(nt_game_over)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_state(input string tag, input int e_led, input int e_code,
                           input int e_await, input int e_level, input int e_won,
                           input int e_over);
    chk({tag, ".led_en"},         32'(led_en),         e_led);
    chk({tag, ".led_code"},       32'(led_code),       e_code);
    chk({tag, ".awaiting_input"}, 32'(awaiting_input), e_await);
    chk({tag, ".level"},          32'(level),          e_level);
    chk({tag, ".game_won"},       32'(game_won),       e_won);
    chk({tag, ".game_over"},      32'(game_over),      e_over);
  endtask

  // Moves to the next negedge: outputs are then stable, pulses drop, rand_in changes.
  task automatic tick();
    @(negedge clk);
    rand_in   = 2'($urandom_range(0, 3));
    btn_code  = 2'($urandom_range(0, 3));
    start     = 1'b0;
    btn_valid = 1'b0;
  endtask

  task automatic inject_noise();
    if (noise) begin
      if ($urandom_range(0, 2) == 0) btn_valid = 1'b1;
      if ($urandom_range(0, 3) == 0) start = 1'b1;
    end
  endtask

  // Entered while observing the ADD cycle; leaves while observing the first INPUT cycle.
  task automatic add_and_play();
    chk_state("add", 0, 0, 0, seq.size(), 0, 0);
    seq.push_back(int'(rand_in));
    foreach (seq[i]) begin
      for (int c = 0; c < ON_C; c++) begin
        tick();
        chk_state("show_on", 1, seq[i], 0, seq.size(), 0, 0);
        inject_noise();
      end
      for (int c = 0; c < OFF_C; c++) begin
        tick();
        chk_state("show_off", 0, 0, 0, seq.size(), 0, 0);
        inject_noise();
      end
    end
    tick();
    chk_state("input", 0, 0, 1, seq.size(), 0, 0);
  endtask

  // Repeats the whole sequence correctly with random gaps up to the timeout edge.
  task automatic input_round();
    int d;
    foreach (seq[i]) begin
      d = $urandom_range(0, TO_C - 1);
      for (int w = 0; w < d; w++) begin
        tick();
        chk_state("wait", 0, 0, 1, seq.size(), 0, 0);
      end
      btn_valid = 1'b1;
      btn_code  = 2'(seq[i]);
      tick();
      if (i < seq.size() - 1) chk_state("press", 0, 0, 1, seq.size(), 0, 0);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    chk_state("reset", 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    seq.delete();
  endtask

  task automatic begin_game();
    seq.delete();
    start = 1'b1;
    tick();
  endtask

  initial begin
    // Full win with ignored events injected during playback.
    do_reset();
    chk("nt.reset.level", 32'(nt_level), 0);
    noise = 1'b1;
    begin_game();
    for (int r = 0; r < MAX_LEN; r++) begin
      add_and_play();
      input_round();
    end
    noise = 1'b0;
    chk_state("won", 0, 0, 0, MAX_LEN, 1, 0);
    btn_valid = 1'b1;
    tick();
    chk_state("won_hold", 0, 0, 0, MAX_LEN, 1, 0);
    begin_game();
    add_and_play();

    // Wrong press at level 2, then restart.
    do_reset();
    begin_game();
    add_and_play();
    input_round();
    add_and_play();
    btn_valid = 1'b1;
    btn_code  = 2'(seq[0]);
    tick();
    chk_state("press_ok", 0, 0, 1, 2, 0, 0);
    btn_valid = 1'b1;
    btn_code  = 2'((seq[1] + 1) % 4);
    tick();
    chk_state("lost", 0, 0, 0, 2, 0, 1);
    btn_valid = 1'b1;
    btn_code  = 2'(seq[1]);
    tick();
    chk_state("lost_hold", 0, 0, 0, 2, 0, 1);
    begin_game();
    add_and_play();

    // Timeout after TO_C silent input cycles; disabled timeout keeps waiting.
    do_reset();
    begin_game();
    add_and_play();
    for (int w = 1; w < TO_C; w++) begin
      tick();
      chk_state("to_wait", 0, 0, 1, 1, 0, 0);
    end
    tick();
    chk_state("timeout", 0, 0, 0, 1, 0, 1);
    for (int k = 0; k < 100; k++) begin
      tick();
      if (k % 10 == 9) begin
        chk("nt.awaiting_input", 32'(nt_awaiting_input), 1);
        chk("nt.game_over", 32'(nt_game_over), 0);
      end
    end
    chk_state("timeout_hold", 0, 0, 0, 1, 0, 1);

    // Reset during SHOW_ON at level 2.
    do_reset();
    begin_game();
    add_and_play();
    input_round();
    chk_state("add2", 0, 0, 0, 1, 0, 0);
    seq.push_back(int'(rand_in));
    tick();
    chk_state("show_on2", 1, seq[0], 0, 2, 0, 0);
    rst = 1'b1;
    tick();
    chk_state("mid_reset", 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    begin_game();
    add_and_play();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
